cim_row_sequencer: RTL and testbench

//   Command-driven initiator for row_decoder: turns one accepted command into timed
//   MAC_en/read_bar/addr/data sequences. MAC reads pulse each masked row in turn; CAM

---
 rtl/cim_row_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_cim_row_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_row_sequencer.sv
// Command-driven initiator for row_decoder: turns one accepted MAC sweep or CAM search
// into timed MAC_en/read_bar/addr/data phases (SETUP -> PULSE -> RECOV per row).
module cim_row_sequencer #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned RECOV_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [3:0] cmd_mask,
  input  logic [3:0] cmd_key,
  output logic       MAC_en,
  output logic       read_bar,
  output logic [1:0] addr,
  output logic [3:0] data,
  output logic       busy,
  output logic       done,
  output logic [2:0] rows_fired
);

  // Counter load values: a phase of N cycles counts N-1 down to 0.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] RECOV_LD = 8'(RECOV_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_RECOV,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       op_q, op_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] key_q, key_d;
  logic       mac_en_q, mac_en_d;
  logic       read_bar_q, read_bar_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] data_q, data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;
  logic [2:0] rows_q, rows_d;

  function automatic logic [1:0] lowest_row(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic logic [3:0] drop_lowest(input logic [3:0] m);
    return m & (m - 4'd1);
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    mask_d     = mask_q;
    key_d      = key_q;
    mac_en_d   = mac_en_q;
    read_bar_d = read_bar_q;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ready_d    = ready_q;
    rows_d     = rows_q;

    case (state_q)
      S_IDLE: begin
        mac_en_d   = 1'b1;
        read_bar_d = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          key_d   = cmd_key;
          rows_d  = 3'd0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          if (!cmd_op && cmd_mask == 4'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            mask_d  = 4'd0;
          end else begin
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
            if (cmd_op) begin
              addr_d = 2'd0;
              data_d = cmd_key;
              mask_d = 4'd0;
            end else begin
              // mask_q keeps only the rows still to be visited after this one.
              addr_d = lowest_row(cmd_mask);
              data_d = 4'd0;
              mask_d = drop_lowest(cmd_mask);
            end
          end
        end
      end

      S_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_PULSE;
          cnt_d   = PULSE_LD;
          rows_d  = rows_q + 3'd1;
          if (op_q) mac_en_d = 1'b0;
          else      read_bar_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_PULSE: begin
        if (cnt_q == 8'd0) begin
          state_d    = S_RECOV;
          cnt_d      = RECOV_LD;
          mac_en_d   = 1'b1;
          read_bar_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_RECOV: begin
        if (cnt_q == 8'd0) begin
          if (!op_q && mask_q != 4'd0) begin
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
            addr_d  = lowest_row(mask_q);
            data_d  = 4'd0;
            mask_d  = drop_lowest(mask_q);
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end

      default: begin
        state_d    = S_IDLE;
        mac_en_d   = 1'b1;
        read_bar_d = 1'b1;
        busy_d     = 1'b0;
        ready_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      op_q       <= 1'b0;
      mask_q     <= 4'd0;
      key_q      <= 4'd0;
      mac_en_q   <= 1'b1;
      read_bar_q <= 1'b1;
      addr_q     <= 2'd0;
      data_q     <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      rows_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      mask_q     <= mask_d;
      key_q      <= key_d;
      mac_en_q   <= mac_en_d;
      read_bar_q <= read_bar_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      rows_q     <= rows_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign MAC_en     = mac_en_q;
  assign read_bar   = read_bar_q;
  assign addr       = addr_q;
  assign data       = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rows_fired = rows_q;

endmodule

// File: tb/tb_cim_row_sequencer.sv
// Directed bench for cim_row_sequencer: one instance with default phase lengths and one
// with SETUP_CYC=3, PULSE_CYC=1; expected results come from a scoreboard queue.
module tb_cim_row_sequencer;

  localparam int S0 = 1, P0 = 2, R0 = 1;
  localparam int S1 = 3, P1 = 1, R1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n[2];
  logic       cmd_valid[2];
  logic       cmd_ready[2];
  logic       cmd_op[2];
  logic [3:0] cmd_mask[2];
  logic [3:0] cmd_key[2];
  logic       MAC_en[2];
  logic       read_bar[2];
  logic [1:0] addr[2];
  logic [3:0] data[2];
  logic       busy[2];
  logic       done[2];
  logic [2:0] rows_fired[2];

  cim_row_sequencer #(.SETUP_CYC(S0), .PULSE_CYC(P0), .RECOV_CYC(R0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_mask(cmd_mask[0]), .cmd_key(cmd_key[0]),
    .MAC_en(MAC_en[0]), .read_bar(read_bar[0]), .addr(addr[0]), .data(data[0]),
    .busy(busy[0]), .done(done[0]), .rows_fired(rows_fired[0])
  );

  cim_row_sequencer #(.SETUP_CYC(S1), .PULSE_CYC(P1), .RECOV_CYC(R1)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_mask(cmd_mask[1]), .cmd_key(cmd_key[1]),
    .MAC_en(MAC_en[1]), .read_bar(read_bar[1]), .addr(addr[1]), .data(data[1]),
    .busy(busy[1]), .done(done[1]), .rows_fired(rows_fired[1])
  );

  typedef struct {
    int         lat;
    int         rows;
    int         rb_low;
    int         men_low;
    int         first_pulse;
    int         pulse_len;
    logic [3:0] key;
  } exp_t;

  exp_t sb[$];
  int   exp_addr[$];
  int   total = 0;
  int   bad = 0;

  function automatic int setupOf(input int sel);
    return (sel == 0) ? S0 : S1;
  endfunction
  function automatic int pulseOf(input int sel);
    return (sel == 0) ? P0 : P1;
  endfunction
  function automatic int recovOf(input int sel);
    return (sel == 0) ? R0 : R1;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one command for its accept edge and record what it must produce.
  task automatic applyStimulus(input int sel, input logic op, input logic [3:0] mask,
                               input logic [3:0] key, input bit hold);
    exp_t e;
    int   n;
    cmd_valid[sel] = 1'b1;
    cmd_op[sel]    = op;
    cmd_mask[sel]  = mask;
    cmd_key[sel]   = key;
    check("ready_at_accept", cmd_ready[sel], 1);
    n = 0;
    if (op) n = 1;
    else for (int r = 0; r < 4; r++) if (mask[r]) n++;
    e.lat         = (n == 0) ? 1 : 1 + n * (setupOf(sel) + pulseOf(sel) + recovOf(sel));
    e.rows        = n;
    e.rb_low      = op ? 0 : n * pulseOf(sel);
    e.men_low     = op ? pulseOf(sel) : 0;
    e.first_pulse = (n == 0) ? 0 : setupOf(sel) + 1;
    e.pulse_len   = pulseOf(sel);
    e.key         = key;
    if (!op) begin
      for (int r = 0; r < 4; r++)
        if (mask[r]) for (int k = 0; k < pulseOf(sel); k++) exp_addr.push_back(r);
    end
    sb.push_back(e);
    tick();
    if (!hold) cmd_valid[sel] = 1'b0;
  endtask

  // Follow the command cycle by cycle until done, comparing against the scoreboard.
  task automatic checkOutput(input int sel, input string tag, input bit hold);
    exp_t e;
    int   cyc, rbl, mnl, first, run, ea;
    bit   seen;
    e = sb.pop_front();
    cyc = 1; rbl = 0; mnl = 0; first = 0; run = 0; seen = 1'b0;
    while (cyc <= 500 && !seen) begin
      check({tag, "_overlap"}, 32'(!read_bar[sel] && !MAC_en[sel]), 0);
      check({tag, "_busy"}, busy[sel], 1);
      if (read_bar[sel] === 1'b0) begin
        rbl++;
        run++;
        if (first == 0) first = cyc;
        ea = (exp_addr.size() > 0) ? exp_addr.pop_front() : -1;
        check({tag, "_addr"}, 32'(addr[sel]), ea);
      end else if (run > 0) begin
        check({tag, "_pulse_len"}, run, e.pulse_len);
        run = 0;
      end
      if (MAC_en[sel] === 1'b0) begin
        mnl++;
        if (first == 0) first = cyc;
        check({tag, "_key"}, data[sel], 32'(e.key));
      end
      if (done[sel] === 1'b1) begin
        seen = 1'b1;
        check({tag, "_latency"}, cyc, e.lat);
        check({tag, "_rows_fired"}, rows_fired[sel], e.rows);
        check({tag, "_rb_low_cycles"}, rbl, e.rb_low);
        check({tag, "_macen_low_cycles"}, mnl, e.men_low);
        check({tag, "_first_pulse"}, first, e.first_pulse);
      end else begin
        if (hold) cmd_mask[sel] = 4'($urandom);
        tick();
        cyc++;
      end
    end
    if (!seen) check({tag, "_timeout"}, cyc, e.lat);
  endtask

  task automatic afterDone(input int sel, input string tag, input int rows);
    tick();
    check({tag, "_idle_busy"}, busy[sel], 0);
    check({tag, "_idle_ready"}, cmd_ready[sel], 1);
    check({tag, "_idle_done"}, done[sel], 0);
    check({tag, "_idle_rows"}, rows_fired[sel], rows);
    check({tag, "_idle_macen"}, MAC_en[sel], 1);
    check({tag, "_idle_rb"}, read_bar[sel], 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; cmd_valid[s] = 1'b0; cmd_op[s] = 1'b0;
      cmd_mask[s] = 4'd0; cmd_key[s] = 4'd0;
    end
    repeat (2) tick();
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    tick();

    // Reset state
    check("rst_macen", MAC_en[0], 1);
    check("rst_rb", read_bar[0], 1);
    check("rst_addr", addr[0], 0);
    check("rst_data", data[0], 0);
    check("rst_ready", cmd_ready[0], 1);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_rows", rows_fired[0], 0);

    // MAC sweep over rows 1 and 3
    applyStimulus(0, 1'b0, 4'b1010, 4'hF, 1'b0);
    checkOutput(0, "mac1010", 1'b0);
    afterDone(0, "mac1010", 2);
    check("mac1010_addr_hold", addr[0], 3);
    check("mac1010_data_hold", data[0], 0);

    // CAM search
    applyStimulus(0, 1'b1, 4'b1010, 4'b1010, 1'b0);
    checkOutput(0, "cam1010", 1'b0);
    afterDone(0, "cam1010", 1);
    check("cam1010_data_hold", data[0], 4'b1010);
    check("cam1010_addr_hold", addr[0], 0);

    // Empty mask finishes in one cycle
    applyStimulus(0, 1'b0, 4'b0000, 4'h0, 1'b0);
    checkOutput(0, "mac0000", 1'b0);
    afterDone(0, "mac0000", 0);

    // Asynchronous reset during the second row's pulse
    cmd_valid[0] = 1'b1; cmd_op[0] = 1'b0; cmd_mask[0] = 4'b1111;
    tick();
    cmd_valid[0] = 1'b0;
    repeat (5) tick();
    check("midrst_pre_rb", read_bar[0], 0);
    check("midrst_pre_addr", addr[0], 1);
    #2 rst_n[0] = 1'b0;
    #1;
    check("midrst_rb", read_bar[0], 1);
    check("midrst_busy", busy[0], 0);
    check("midrst_macen", MAC_en[0], 1);
    check("midrst_addr", addr[0], 0);
    check("midrst_rows", rows_fired[0], 0);
    check("midrst_ready", cmd_ready[0], 1);
    tick();
    rst_n[0] = 1'b1;
    tick();
    applyStimulus(0, 1'b1, 4'h0, 4'b0110, 1'b0);
    checkOutput(0, "postrst_cam", 1'b0);
    afterDone(0, "postrst_cam", 1);

    // Back-to-back on the SETUP=3/PULSE=1 instance with cmd_valid held high
    applyStimulus(1, 1'b0, 4'b1010, 4'h0, 1'b1);
    checkOutput(1, "b2b_first", 1'b1);
    tick();
    check("b2b_gap_busy", busy[1], 0);
    check("b2b_gap_ready", cmd_ready[1], 1);
    check("b2b_gap_rows", rows_fired[1], 2);
    applyStimulus(1, 1'b0, 4'b0101, 4'h0, 1'b0);
    checkOutput(1, "b2b_second", 1'b0);
    afterDone(1, "b2b_second", 2);
    check("addr_queue_drained", exp_addr.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
